// File: rtl/kgp_risc_pkg.sv
// Shared types and constants for the KGP-RISC instruction sequencer.
// Used by kgp_risc_sequencer (optional stall counter macro: KGP_SEQ_PERF_EN).
package kgp_risc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] OP_MEM   = 2'd0;
    localparam logic [1:0] OP_ALU   = 2'd1;
    localparam logic [1:0] OP_SHIFT = 2'd2;
    localparam logic [1:0] OP_BR    = 2'd3;

    localparam logic [3:0] MAXF_MEM   = 4'd1;
    localparam logic [3:0] MAXF_ALU   = 4'd8;
    localparam logic [3:0] MAXF_SHIFT = 4'd4;
    localparam logic [3:0] MAXF_BR    = 4'd11;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_REG    = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic fcode_legal(input logic [1:0] op, input logic [3:0] fc);
        logic [3:0] max_f;
        case (op)
            OP_MEM:   max_f = MAXF_MEM;
            OP_ALU:   max_f = MAXF_ALU;
            OP_SHIFT: max_f = MAXF_SHIFT;
            OP_BR:    max_f = MAXF_BR;
            default:  max_f = 4'd0;
        endcase
        return (fc <= max_f);
    endfunction

endpackage

// File: rtl/kgp_mem_wait_timer.sv
// Counts memory request cycles without acknowledge; flags the last allowed cycle.
module kgp_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt_r;

    // Wait-cycle counter: holds the number of unacknowledged cycles already spent
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 8'd0;
        end else if (clear) begin
            wait_cnt_r <= 8'd0;
        end else if (count) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The current request cycle is the MEM_TIMEOUT-th one
    assign timeout = (wait_cnt_r == LIMIT);

endmodule

// File: rtl/kgp_risc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC core.
// Define KGP_SEQ_PERF_EN to enable the saturating memory stall counter.
module kgp_risc_sequencer
    import kgp_risc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       opcode,
    input  logic [3:0]       fcode,
    input  logic             branch,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             regWrite,
    input  logic             reg2PC,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             alu_en,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count,
    output logic [31:0]      stall_count
);

    state_t           state_r;
    state_t           next_state_s;
    logic [1:0]       err_code_r;
    logic [1:0]       err_code_nxt_s;
    logic [CNT_W-1:0] instr_count_r;
    logic             timeout_s;
    logic             timer_clear_s;
    state_t           retire_state_s;

    assign retire_state_s = run ? FETCH : IDLE;
    assign timer_clear_s  = !((state_r == FETCH) || (state_r == MEM)) || mem_ack;

    kgp_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .count   (mem_req && !mem_ack),
        .timeout (timeout_s)
    );

    // State, fault code and retired-instruction counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            err_code_r    <= ERR_NONE;
            instr_count_r <= '0;
        end else begin
            state_r    <= next_state_s;
            err_code_r <= err_code_nxt_s;
            if (pc_we) begin
                instr_count_r <= instr_count_r + CNT_W'(1);
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // Next-state and strobe decode; ack always wins over the timeout
    always_comb begin
        next_state_s   = state_r;
        err_code_nxt_s = err_code_r;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr_sel   = 1'b0;
        ir_we          = 1'b0;
        mdr_we         = 1'b0;
        alu_en         = 1'b0;
        rf_we          = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_SEL_PLUS4;
        case (state_r)
            IDLE: begin
                next_state_s = run ? FETCH : IDLE;
            end
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                if (mem_ack) begin
                    next_state_s = DECODE;
                end else if (timeout_s) begin
                    next_state_s   = ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                if (fcode_legal(opcode, fcode)) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s   = ERROR;
                    err_code_nxt_s = ERR_ILLEGAL;
                end
            end
            EXEC: begin
                alu_en = 1'b1;
                if (memRead || memWrite) begin
                    next_state_s = MEM;
                end else if (regWrite) begin
                    next_state_s = WB;
                end else begin
                    pc_we        = 1'b1;
                    pc_sel       = reg2PC ? PC_SEL_REG :
                                   (branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4);
                    next_state_s = retire_state_s;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = memWrite;
                if (mem_ack) begin
                    if (memWrite) begin
                        pc_we        = 1'b1;
                        next_state_s = retire_state_s;
                    end else begin
                        mdr_we       = 1'b1;
                        next_state_s = WB;
                    end
                end else if (timeout_s) begin
                    next_state_s   = ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    next_state_s = MEM;
                end
            end
            WB: begin
                rf_we        = 1'b1;
                pc_we        = 1'b1;
                pc_sel       = reg2PC ? PC_SEL_REG : PC_SEL_PLUS4;
                next_state_s = retire_state_s;
            end
            ERROR: begin
                next_state_s = ERROR;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign busy        = (state_r != IDLE) && (state_r != ERROR);
    assign err         = (state_r == ERROR);
    assign err_code    = err_code_r;
    assign instr_count = instr_count_r;

`ifdef KGP_SEQ_PERF_EN
    logic [31:0] stall_count_r;

    // Saturating count of request cycles that were not acknowledged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= 32'd0;
        end else if (mem_req && !mem_ack && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: doc/kgp_risc_sequencer.md
Name: kgp_risc_sequencer

Overview:
- Multi-cycle instruction sequencer for the KGP-RISC core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file and memory strobes.
- Shares one single-port memory between instruction fetch and load/store, with a ready/ack handshake and a timeout.
- Consumes the decoded control bits from the combinational decoder; it does not decode ALU operations itself.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before entering ERROR (legal range 1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
run  in  1  1 = execute; 0 = stop at the next instruction boundary
opcode  in  2  from IR[31:30]
fcode  in  4  from IR function field
branch, memRead, memWrite, regWrite, reg2PC  in  1 each  decoder outputs
branch_taken  in  1  ALU flag compare result, valid in EXEC
mem_ack  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, qualified by mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR
mdr_we  out  1  latch read data
alu_en  out  1  latch ALU result/flags
rf_we  out  1  register-file write
pc_we  out  1  PC update (retire)
pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = register, 11 = unused
busy  out  1  state not IDLE/ERROR
err  out  1  sticky fault
err_code  out  2  01 = illegal instruction, 10 = memory timeout
instr_count  out  CNT_W  retired instructions
stall_count  out  32  memory wait cycles (optional feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; wait timer 0.
- A mid-instruction reset abandons the instruction with no pc_we.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - ir_we = mem_ack (Mealy, same cycle); on ack go to DECODE.
- DECODE: one cycle; checks legality. Legal fcode ranges: op0 0..1, op1 0..8, op2 0..4, op3 0..11.
  - Illegal: go to ERROR with err_code=01.
  - Legal: go to EXEC.
- EXEC: alu_en=1 for one cycle.
  - memRead|memWrite: go to MEM.
  - else regWrite: go to WB.
  - else (branch): pc_we=1 with pc_sel = reg2PC ? 10 : (branch_taken ? 01 : 00); then go to FETCH, or IDLE if run=0.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=memWrite.
  - On ack with a read: mdr_we=1, go to WB.
  - On ack with a write: pc_we=1, pc_sel=00, go to FETCH/IDLE.
- WB: rf_we=1, pc_we=1 for one cycle, then go to FETCH/IDLE.
  - pc_sel = 10 when reg2PC (call, link written); otherwise 00.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU/shift: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Wait timer: cleared on entry to FETCH/MEM; increments each request cycle without ack.
  - No ack in cycle MEM_TIMEOUT: go to ERROR, err_code=10.
  - Ack in exactly that cycle: completes normally (ack wins).
- ERROR: all strobes 0, err=1, busy=0; left only by reset.
- instr_count: +1 on every pc_we; wraps at 2^CNT_W.
- run=0 never aborts an instruction; it is sampled only at retirement.
- run is ignored in ERROR.

Optional Feature:
- Macro KGP_SEQ_PERF_EN.
- Defined: stall_count +1 every FETCH/MEM cycle with mem_req=1 and mem_ack=0; saturates at 2^32-1; cleared by reset.
- Undefined: stall_count tied to 0, no counter logic.

Decomposition:
- Package kgp_risc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR);
  - opcode constants (OP_MEM=0, OP_ALU=1, OP_SHIFT=2, OP_BR=3);
  - per-opcode max-fcode constants;
  - pc_sel encodings;
  - err_code encodings.
- One sub-module, kgp_mem_wait_timer: clear/count inputs, timeout output, parameter MEM_TIMEOUT.

Test Plan:
- Add (op1, fcode0), ack in the first cycle, run=1 → ir_we at t0; alu_en t2; rf_we+pc_we t3, pc_sel=00; instr_count=1.
- Load (op0 f0), data ack delayed 3 cycles → mem_addr_sel=1 for 4 cycles; mdr_we on ack; rf_we next cycle; 8 cycles total.
- Branch (op3 f1), branch_taken=1 → pc_we in EXEC with pc_sel=01; no rf_we. Jr (op3 f0) → pc_sel=10.
- Illegal op1 fcode9 → ERROR after DECODE, err=1, err_code=01; no pc_we; stays until rst=0.
- mem_ack held low in FETCH with MEM_TIMEOUT=15 → ERROR entered after the 15th request cycle, err_code=10. Repeat with ack in cycle 15 → completes normally.
- run dropped during MEM of a store, then rst pulsed low mid-FETCH:
  - Store retires, then IDLE.
  - Reset forces all outputs 0 immediately.
  - With KGP_SEQ_PERF_EN, stall_count returns to 0.
